// File: rtl/clip_playback_reader_if.sv
// Bus bundle between the clip playback reader, the two clip BRAM read
// ports and the audio/status consumers.
interface clip_playback_reader_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic                     play;
  logic                     stop;
  logic                     loop;
  logic                     clip_sel;
  logic [ADDR_W-1:0]        clip_len;
  logic signed [DATA_W-1:0] douta0;
  logic signed [DATA_W-1:0] douta1;
  logic                     ena0;
  logic                     ena1;
  logic [ADDR_W-1:0]        addra;
  logic                     busy;
  logic                     done;
  logic                     audioOut;

  // Environment side: controls, memory read data; observes reads and audio.
  modport master (
    output play, stop, loop, clip_sel, clip_len, douta0, douta1,
    input  ena0, ena1, addra, busy, done, audioOut
  );

  // Reader side.
  modport slave (
    input  play, stop, loop, clip_sel, clip_len, douta0, douta1,
    output ena0, ena1, addra, busy, done, audioOut
  );
endinterface

// File: rtl/clip_playback_reader.sv
// Clip playback reader: fetches one signed sample per sample period from the
// selected clip BRAM and renders it as an 8-bit-resolution PWM bit stream.
module clip_playback_reader #(
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 16,
  parameter int CLK_PER_SAMPLE = 2500,
  parameter int RD_LAT         = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  clip_playback_reader_if.slave bus
);

  localparam int                CNT_W     = $clog2(CLK_PER_SAMPLE);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLK_PER_SAMPLE - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [DATA_W-1:0] SIGN_BIT  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_LOAD, S_HOLD} state_t;

  // Signed sample to offset-binary duty: flip the sign bit, keep the top 8 bits.
  function automatic logic [7:0] to_duty(input logic signed [DATA_W-1:0] s);
    return 8'((unsigned'(s) ^ SIGN_BIT) >> (DATA_W - 8));
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              sel_q, sel_d;
  logic [7:0]        duty_q, duty_d;
  logic [7:0]        pwm_q, pwm_d;
  logic              done_d;
  logic              ena0_q, ena1_q, busy_q, done_q, aud_q;

  // Next-state, period counter, address and duty capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    sel_d   = sel_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        cnt_d  = '0;
        if (bus.play && !bus.stop) begin
          if (bus.clip_len != '0) begin
            state_d = S_READ;
            len_d   = bus.clip_len;
            sel_d   = bus.clip_sel;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_READ: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (RD_LAT > 1) ? S_WAIT : S_LOAD;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WAIT_LAST) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = cnt_q + 1'b1;
        duty_d  = to_duty(sel_q ? bus.douta1 : bus.douta0);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (addr_q < len_q - 1'b1) begin
            addr_d  = addr_q + 1'b1;
            state_d = S_READ;
          end else if (bus.loop) begin
            addr_d  = '0;
            state_d = S_READ;
          end else begin
            addr_d  = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything else while busy and never produces done.
    if (bus.stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  // PWM carrier: free-runs while busy, starts at 0 in the first READ.
  always_comb begin
    pwm_d = '0;
    if ((state_d != S_IDLE) && (state_q != S_IDLE)) pwm_d = pwm_q + 1'b1;
  end

  // State and registered outputs; all outputs come straight from flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      sel_q   <= 1'b0;
      duty_q  <= '0;
      pwm_q   <= '0;
      ena0_q  <= 1'b0;
      ena1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      aud_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      ena0_q  <= (state_d == S_READ) && !sel_d;
      ena1_q  <= (state_d == S_READ) && sel_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      aud_q   <= (state_d != S_IDLE) && (pwm_d < duty_d);
    end
  end

  assign bus.ena0     = ena0_q;
  assign bus.ena1     = ena1_q;
  assign bus.addra    = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.audioOut = aud_q;

endmodule

// File: tb/tb_clip_playback_reader.sv
// Bench for clip_playback_reader: two instances (8-cycle period / 1-cycle read
// latency, and 512-cycle period / 2-cycle read latency) checked every cycle
// against a timeline model of the playback behaviour.
module tb_clip_playback_reader;

  localparam int CPS0 = 8;
  localparam int LAT0 = 1;
  localparam int CPS1 = 512;
  localparam int LAT1 = 2;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  clip_playback_reader_if #(.ADDR_W(17), .DATA_W(16)) bus0 ();
  clip_playback_reader_if #(.ADDR_W(17), .DATA_W(16)) bus1 ();

  clip_playback_reader #(.ADDR_W(17), .DATA_W(16), .CLK_PER_SAMPLE(CPS0), .RD_LAT(LAT0))
    u0 (.clock(clk), .reset(rst0), .bus(bus0));
  clip_playback_reader #(.ADDR_W(17), .DATA_W(16), .CLK_PER_SAMPLE(CPS1), .RD_LAT(LAT1))
    u1 (.clock(clk), .reset(rst1), .bus(bus1));

  // Clip memories: [dut][clip][addr]. Read data is only valid in the cycle
  // RD_LAT after the enable; otherwise the port shows inverted junk.
  logic [15:0] mem [2][2][16];
  logic [15:0] r0_d0, r0_d1, p1_d0, p1_d1, r1_d0, r1_d1;
  logic        r0_v0, r0_v1, p1_v0, p1_v1, r1_v0, r1_v1;

  always @(posedge clk) begin
    r0_v0 <= bus0.ena0; r0_d0 <= mem[0][0][bus0.addra[3:0]];
    r0_v1 <= bus0.ena1; r0_d1 <= mem[0][1][bus0.addra[3:0]];
    p1_v0 <= bus1.ena0; p1_d0 <= mem[1][0][bus1.addra[3:0]];
    p1_v1 <= bus1.ena1; p1_d1 <= mem[1][1][bus1.addra[3:0]];
    r1_v0 <= p1_v0;     r1_d0 <= p1_d0;
    r1_v1 <= p1_v1;     r1_d1 <= p1_d1;
  end
  assign bus0.douta0 = r0_v0 ? r0_d0 : ~r0_d0;
  assign bus0.douta1 = r0_v1 ? r0_d1 : ~r0_d1;
  assign bus1.douta0 = r1_v0 ? r1_d0 : ~r1_d0;
  assign bus1.douta1 = r1_v1 ? r1_d1 : ~r1_d1;

  // Model state: one playback session per dut, described by its start cycle,
  // length, clip, the cycle offset where busy ends and the done cycle.
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          chk_en = 1'b0;
  logic [15:0] cpm [2][2][16];
  int          s_t [2], s_n [2], s_end [2], s_prev [2], done_at [2];
  bit          s_on [2], s_sel [2];
  int          pwm_hi [3];

  function automatic int cps_of(input int d); return (d == 0) ? CPS0 : CPS1; endfunction
  function automatic int lat_of(input int d); return (d == 0) ? LAT0 : LAT1; endfunction

  // Offset-binary duty of a signed sample: (s + 32768) / 256.
  function automatic int todty(input logic [15:0] s);
    return (int'($signed(s)) + 32768) / 256;
  endfunction

  function automatic bit in_busy(input int d);
    int k;
    k = cyc - s_t[d] - 1;
    return s_on[d] && (k >= 0) && (k < s_end[d]);
  endfunction

  // Duty in effect this cycle: sample i becomes audible RD_LAT+1 cycles into
  // its period, provided its load cycle fell inside the busy window.
  function automatic int cur_duty(input int d);
    int k, lim, m;
    if (!s_on[d]) return s_prev[d];
    k   = cyc - s_t[d] - 1;
    lim = (k < s_end[d]) ? k : s_end[d];
    m   = lim - lat_of(d) - 1;
    if (m < 0) return s_prev[d];
    return todty(cpm[d][s_sel[d]][(m / cps_of(d)) % s_n[d]]);
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic b, input logic e0, input logic e1,
                           input logic dn, input logic au, input logic [16:0] ad);
    int k, cp, xa, du;
    bit xb, xe;
    cp = cps_of(d);
    k  = cyc - s_t[d] - 1;
    xb = in_busy(d);
    xe = xb && (k % cp == 0);
    xa = xb ? (k / cp) % s_n[d] : 0;
    du = cur_duty(d);
    chk("busy", d, b, xb);
    chk("ena0", d, e0, xe && !s_sel[d]);
    chk("ena1", d, e1, xe && s_sel[d]);
    chk("addra", d, ad, xa);
    chk("done", d, dn, cyc == done_at[d]);
    chk("audioOut", d, au, xb && ((k % 256) < du));
  endtask

  // Random play pulses and clip fields while busy; they must be ignored.
  task automatic junk(input int d);
    bit b;
    b = in_busy(d);
    if (d == 0) begin
      bus0.play = b ? 1'($urandom) : 1'b0;
      bus0.clip_sel = 1'($urandom);
      bus0.clip_len = 17'($urandom_range(0, 7));
    end else begin
      bus1.play = b ? 1'($urandom) : 1'b0;
      bus1.clip_sel = 1'($urandom);
      bus1.clip_len = 17'($urandom_range(0, 7));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (chk_en) begin
      check_dut(0, bus0.busy, bus0.ena0, bus0.ena1, bus0.done, bus0.audioOut, bus0.addra);
      check_dut(1, bus1.busy, bus1.ena0, bus1.ena1, bus1.done, bus1.audioOut, bus1.addra);
    end
    junk(0);
    junk(1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic fill(input int d);
    for (int a = 0; a < 16; a++) begin
      mem[d][0][a] = 16'($urandom);
      mem[d][1][a] = 16'($urandom);
    end
  endtask

  task automatic start(input int d, input int n, input bit sel, input bit lp);
    s_prev[d] = cur_duty(d);
    for (int a = 0; a < 16; a++) begin
      cpm[d][0][a] = mem[d][0][a];
      cpm[d][1][a] = mem[d][1][a];
    end
    s_on[d]    = 1'b1;
    s_t[d]     = cyc;
    s_n[d]     = n;
    s_sel[d]   = sel;
    s_end[d]   = lp ? (1 << 30) : n * cps_of(d);
    done_at[d] = lp ? -1 : cyc + 1 + n * cps_of(d);
    if (d == 0) begin
      bus0.play = 1'b1; bus0.stop = 1'b0; bus0.loop = lp; bus0.clip_sel = sel; bus0.clip_len = 17'(n);
    end else begin
      bus1.play = 1'b1; bus1.stop = 1'b0; bus1.loop = lp; bus1.clip_sel = sel; bus1.clip_len = 17'(n);
    end
    step();
  endtask

  task automatic empty_clip(input int d);
    done_at[d] = cyc + 1;
    if (d == 0) begin bus0.play = 1'b1; bus0.clip_len = '0; bus0.loop = 1'b0; end
    else        begin bus1.play = 1'b1; bus1.clip_len = '0; bus1.loop = 1'b0; end
    step();
  endtask

  task automatic do_stop(input int d);
    s_end[d]   = cyc - s_t[d];
    done_at[d] = -1;
    if (d == 0) bus0.stop = 1'b1; else bus1.stop = 1'b1;
    step();
    bus0.stop = 1'b0;
    bus1.stop = 1'b0;
  endtask

  task automatic do_reset(input int d);
    s_on[d]    = 1'b0;
    s_prev[d]  = 0;
    done_at[d] = -1;
    if (d == 0) rst0 = 1'b1; else rst1 = 1'b1;
    step();
    rst0 = 1'b0;
    rst1 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    bit sel;
    for (int d = 0; d < 2; d++) begin
      s_t[d] = 0; s_n[d] = 1; s_end[d] = 0; s_prev[d] = 0; done_at[d] = -1;
      s_on[d] = 1'b0; s_sel[d] = 1'b0;
      for (int a = 0; a < 16; a++) begin
        mem[d][0][a] = '0; mem[d][1][a] = '0; cpm[d][0][a] = '0; cpm[d][1][a] = '0;
      end
    end
    for (int i = 0; i < 3; i++) pwm_hi[i] = 0;
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.play = 1'b0; bus0.stop = 1'b0; bus0.loop = 1'b0; bus0.clip_sel = 1'b0; bus0.clip_len = '0;
    bus1.play = 1'b0; bus1.stop = 1'b0; bus1.loop = 1'b0; bus1.clip_sel = 1'b0; bus1.clip_len = '0;

    // Reset state, checked while reset is still held and just after release.
    run(2);
    chk_en = 1'b1;
    run(1);
    rst0 = 1'b0; rst1 = 1'b0;
    run(3);

    // Single full-scale sample on memory1.
    mem[0][0][0] = 16'h7FFF;
    start(0, 1, 1'b0, 1'b0);
    run(12);

    // Three samples from memory2: duties 0, 128, 192.
    mem[0][1][0] = 16'h8000; mem[0][1][1] = 16'h0000; mem[0][1][2] = 16'h4000;
    start(0, 3, 1'b1, 1'b0);
    run(28);

    // Looping two-sample clip; loop dropped inside the second address-1 period.
    fill(0);
    start(0, 2, 1'($urandom), 1'b1);
    run(3 * CPS0 + 2);
    bus0.loop  = 1'b0;
    s_end[0]   = 4 * CPS0;
    done_at[0] = s_t[0] + 1 + 4 * CPS0;
    run(12);

    // Stop in HOLD, then a fresh play restarts at address 0.
    fill(0);
    start(0, 4, 1'b0, 1'b0);
    run(CPS0 + 4);
    do_stop(0);
    run(3);
    fill(0);
    start(0, 3, 1'b1, 1'b0);
    run(3 * CPS0 + 3);

    // Reset during LOAD.
    fill(0);
    start(0, 3, 1'b0, 1'b0);
    run(LAT0);
    do_reset(0);
    run(3);

    // play together with stop in IDLE does not start.
    bus0.play = 1'b1; bus0.stop = 1'b1; bus0.clip_len = 17'd3;
    step();
    bus0.stop = 1'b0;
    run(4);

    // Empty clip.
    empty_clip(0);
    run(4);

    // Randomized sessions, some looping with a random abort.
    for (int r = 0; r < 8; r++) begin
      fill(0);
      n   = $urandom_range(1, 5);
      sel = 1'($urandom);
      if (r % 3 == 2) begin
        start(0, n, sel, 1'b1);
        run($urandom_range(5, 60));
        do_stop(0);
        run($urandom_range(1, 4));
      end else begin
        start(0, n, sel, 1'b0);
        run(n * CPS0 + $urandom_range(1, 5));
      end
    end

    // Long period, two-cycle read latency: PWM high counts over full carrier cycles.
    mem[1][1][0] = 16'h8000; mem[1][1][1] = 16'h0000; mem[1][1][2] = 16'h4000;
    start(1, 3, 1'b1, 1'b0);
    for (int j = 1; j <= 3 * CPS1 + 2; j++) begin
      step();
      if ((j < 3 * CPS1) && ((j % CPS1) >= 256)) pwm_hi[j / CPS1] += int'(bus1.audioOut);
    end
    chk("pwm_hi0", 1, pwm_hi[0], 0);
    chk("pwm_hi1", 1, pwm_hi[1], 128);
    chk("pwm_hi2", 1, pwm_hi[2], 192);

    empty_clip(1);
    run(4);
    fill(1);
    start(1, 1, 1'b0, 1'b0);
    run(CPS1 + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clip_playback_reader.md
# clip_playback_reader

Playback engine for the two-clip audio recorder. It reads 16-bit signed samples from one of the two clip BRAMs at a fixed sample rate and turns each sample into a 1-bit PWM stream on `audioOut`. It is the read side of the clip memories, complementing the record path that writes them, and sits between the BRAM instances and the audio output pin.

## Interface
- `ADDR_W`, 17: BRAM address width.
- `DATA_W`, 16: BRAM sample width, signed two's complement.
- `CLK_PER_SAMPLE`, 2500: clock cycles per sample period. Must be ≥ `RD_LAT`+2.
- `RD_LAT`, 1: BRAM read latency in cycles. Legal values are 1 and 2.

- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `play` in 1: one-cycle start pulse. Only honoured in IDLE.
- `stop` in 1: abort. Returns the block to IDLE without a `done` pulse.
- `loop` in 1: when 1, wrap to address 0 after the last sample. Sampled continuously.
- `clip_sel` in 1: clip to play (0 = memory1, 1 = memory2). Latched on start.
- `clip_len` in ADDR_W: number of valid samples in the clip. Latched on start.
- `douta0` in DATA_W: read data from memory1.
- `douta1` in DATA_W: read data from memory2.
- `ena0` out 1: read enable for memory1.
- `ena1` out 1: read enable for memory2.
- `addra` out ADDR_W: read address, shared by both memories.
- `busy` out 1: high from the cycle after start until IDLE is re-entered.
- `done` out 1: one-cycle pulse when a non-looping clip finishes.
- `audioOut` out 1: PWM audio.

## Operation
- States:
  - IDLE: no reads; `audioOut` is 0.
  - READ: one cycle, asserts `ena0` or `ena1` per the latched clip.
  - WAIT: `RD_LAT`−1 cycles.
  - LOAD: one cycle, captures the selected `douta` into the sample register.
  - HOLD: waits out the rest of the sample period.
- Start: `play`=1 in IDLE with `clip_len`≠0 latches `clip_sel` and `clip_len`, sets `addra`=0 and goes to READ.
- Empty clip: `play` with `clip_len`=0 stays in IDLE, pulses `done` the next cycle and issues no read.
- Period counter: 0..`CLK_PER_SAMPLE`−1. It is 0 in READ and increments every busy cycle. HOLD exits when the counter equals `CLK_PER_SAMPLE`−1.
- HOLD exit with `addra` < latched `clip_len`−1: increment `addra` and go to READ.
- HOLD exit at the last address with `loop`=1: set `addra`=0 and go to READ.
- HOLD exit at the last address with `loop`=0: go to IDLE, pulse `done` for one cycle, set `addra`=0.
- Duty: 8 bits, `{~s[15], s[14:8]}`, where s is the captured sample (offset binary). −32768 maps to 0 and +32767 maps to 255.
- PWM: an 8-bit counter free-runs while busy and is cleared in IDLE. `audioOut` = (counter < duty). Duty 0 gives a constant 0.
- Duty register: reset value 0. It is updated only at the end of LOAD.
- `stop`=1 in any busy state: IDLE next cycle, `busy`=0, `audioOut`=0, `addra`=0, no `done`.
- `play`=1 and `stop`=1 together in IDLE: `stop` wins and no start occurs.
- `play` while busy is ignored, and `clip_sel`/`clip_len` changes while busy are ignored.
- Reset values: `ena0`=`ena1`=0, `addra`=0, `busy`=0, `done`=0, `audioOut`=0, state IDLE, duty 0, all counters 0. Reset mid-playback aborts immediately and produces no `done`.

## Timing
- `play` in cycle T:
  - T+1: READ, `ena` high, `addra`=0.
  - T+1+`RD_LAT`: LOAD.
  - T+2+`RD_LAT`: new duty is effective.
- Read strobes are exactly `CLK_PER_SAMPLE` cycles apart with no drift, including across a loop wrap.
- `ena0`/`ena1` are high in READ only, and never both high.
- `addra` is stable from READ through LOAD.
- Clip of N samples, no loop, no stop: `busy` is high for exactly N×`CLK_PER_SAMPLE` cycles. `done` is asserted in the first cycle after `busy` falls.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Single-sample clip, `CLK_PER_SAMPLE`=8, `RD_LAT`=1, `douta0`=16'h7FFF, `play` at T:
  - `ena0` high only at T+1, `addra`=0.
  - Duty 255 from T+3.
  - `busy` high T+1..T+8, `done` pulse at T+9.
  - `ena1` never high.
- clip_sel=1, `clip_len`=3, memory2 = {16'h8000, 16'h0000, 16'h4000}:
  - Read addresses 0, 1, 2 at 8-cycle spacing via `ena1`.
  - Duties 0, 128, 192.
  - `audioOut` high for 0, 128 and 192 of every 256 PWM cycles respectively (use `CLK_PER_SAMPLE`=512).
- `loop`=1, `clip_len`=2: reads at addresses 0, 1, 0, 1, … evenly spaced and no `done`. Dropping `loop` before the second address-1 period ends gives `done` after that period.
- `stop` asserted mid-HOLD: next cycle `busy`=0, `audioOut`=0, `addra`=0, no `done`. A subsequent `play` restarts at address 0.
- `reset` asserted mid-LOAD: all outputs return to reset values next cycle. `play` together with `stop` in IDLE produces no start.
- `clip_len`=0 with `play`: `done` pulse next cycle, no `ena`, `busy` stays 0. Repeat with `RD_LAT`=2 and confirm LOAD falls at T+3.
